// File: rtl/rom_access_sequencer.sv
// rom_access_sequencer: runs external SRAM bus cycles for SNES reads/writes and fills idle gaps with MCU accesses.
// SNES requests wait in a 1-entry slot; an access always runs to completion before the next is chosen.
module rom_access_sequencer #(
    parameter int SRAM_WAIT = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_snes_rd_start,
    input  logic        i_snes_wr_end,
    input  logic [23:0] i_map_addr,
    input  logic        i_map_writable,
    input  logic [7:0]  i_snes_din,
    output logic [7:0]  o_snes_dout,
    input  logic        i_mcu_rrq,
    input  logic        i_mcu_wrq,
    input  logic [23:0] i_mcu_addr,
    input  logic [7:0]  i_mcu_wdata,
    output logic [7:0]  o_mcu_rdata,
    output logic        o_mcu_rdy,
    output logic [22:0] o_rom_addr,
    output logic [15:0] o_rom_dq,
    output logic        o_rom_dq_oe,
    input  logic [15:0] i_rom_dq,
    output logic        o_rom_ce_n,
    output logic        o_rom_oe_n,
    output logic        o_rom_we_n,
    output logic        o_rom_ble_n,
    output logic        o_rom_bhe_n,
    output logic        o_snes_overrun
);
    typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;
    localparam logic [3:0] WAIT_CNT = 4'(SRAM_WAIT);

    state_t      r_state, w_next;
    logic        r_pend_v, r_pend_wr;
    logic [23:0] r_pend_addr;
    logic [7:0]  r_pend_data;
    logic        r_wr, r_snes;
    logic [23:0] r_addr;
    logic [7:0]  r_data;
    logic [3:0]  r_cnt;
    logic [7:0]  r_snes_dout, r_mcu_rdata;
    logic        r_overrun;

    logic        w_snes_req, w_req_wr, w_start, w_last, w_acc;
    logic        w_go_snes, w_go_wr;
    logic [23:0] w_go_addr;
    logic [7:0]  w_go_data, w_byte;

    assign w_snes_req = i_snes_rd_start | (i_snes_wr_end & i_map_writable);
    assign w_req_wr   = ~i_snes_rd_start;
    assign w_acc      = r_state == ACCESS;
    assign w_last     = w_acc && r_cnt == 4'd1;
    assign w_byte     = r_addr[0] ? i_rom_dq[15:8] : i_rom_dq[7:0];

    // A request arriving in IDLE bypasses the slot so it starts on the edge that sees it.
    always_comb begin
        w_go_snes = w_snes_req | r_pend_v;
        w_go_wr   = w_snes_req ? w_req_wr : r_pend_v ? r_pend_wr : ~i_mcu_rrq;
        w_go_addr = w_snes_req ? i_map_addr : r_pend_v ? r_pend_addr : i_mcu_addr;
        w_go_data = w_snes_req ? i_snes_din : r_pend_v ? r_pend_data : i_mcu_wdata;
        w_start   = r_state == IDLE && (w_go_snes | i_mcu_rrq | i_mcu_wrq);
        w_next    = r_state == IDLE ? (w_start ? ACCESS : IDLE) :
                    r_state == ACCESS ? (w_last ? TURN : ACCESS) : IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_pend_v    <= 1'b0;
            r_pend_wr   <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_wr        <= 1'b0;
            r_snes      <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_snes_dout <= '0;
            r_mcu_rdata <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_overrun <= r_overrun | (w_snes_req & r_pend_v);
            if (r_state == IDLE)
                r_pend_v <= 1'b0;
            else if (w_snes_req) begin
                r_pend_v    <= 1'b1;
                r_pend_wr   <= w_req_wr;
                r_pend_addr <= i_map_addr;
                r_pend_data <= i_snes_din;
            end
            if (w_start) begin
                r_wr   <= w_go_wr;
                r_snes <= w_go_snes;
                r_addr <= w_go_addr;
                r_data <= w_go_data;
                r_cnt  <= WAIT_CNT;
            end else if (w_acc)
                r_cnt <= r_cnt - 4'd1;
            if (w_last && !r_wr) begin
                if (r_snes)
                    r_snes_dout <= w_byte;
                else
                    r_mcu_rdata <= w_byte;
            end
        end
    end

    assign o_rom_ce_n     = ~w_acc;
    assign o_rom_oe_n     = ~(w_acc & ~r_wr);
    assign o_rom_dq_oe    = w_acc & r_wr;
    assign o_rom_we_n     = ~(w_acc & r_wr & (r_cnt != WAIT_CNT));
    assign o_rom_ble_n    = ~(w_acc & ~r_addr[0]);
    assign o_rom_bhe_n    = ~(w_acc & r_addr[0]);
    assign o_rom_addr     = r_addr[23:1];
    assign o_rom_dq       = {r_data, r_data};
    assign o_mcu_rdy      = (r_state == TURN) & ~r_snes;
    assign o_mcu_rdata    = r_mcu_rdata;
    assign o_snes_dout    = r_snes_dout;
    assign o_snes_overrun = r_overrun;
endmodule

// File: tb/tb_rom_access_sequencer.sv
// tb_rom_access_sequencer: table-driven SNES accesses against a small SRAM model,
// plus hand-written MCU arbitration, overrun and mid-access reset sequences.
module tb_rom_access_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        snes_rd_start = 0, snes_wr_end = 0, map_writable = 0;
    logic [23:0] map_addr = '0, mcu_addr = '0;
    logic [7:0]  snes_din = '0, mcu_wdata = '0;
    logic        mcu_rrq = 0, mcu_wrq = 0;
    logic [7:0]  snes_dout, mcu_rdata;
    logic        mcu_rdy, rom_dq_oe, rom_ce_n, rom_oe_n, rom_we_n, rom_ble_n, rom_bhe_n, snes_overrun;
    logic [22:0] rom_addr;
    logic [15:0] rom_dq_o, rom_dq_i;

    logic [15:0] mem [256];
    logic        pre_we = 0;
    logic [7:0]  pre_a = '0;
    logic [15:0] pre_d = '0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    rom_access_sequencer #(.SRAM_WAIT(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_snes_rd_start(snes_rd_start), .i_snes_wr_end(snes_wr_end),
        .i_map_addr(map_addr), .i_map_writable(map_writable), .i_snes_din(snes_din),
        .o_snes_dout(snes_dout),
        .i_mcu_rrq(mcu_rrq), .i_mcu_wrq(mcu_wrq), .i_mcu_addr(mcu_addr), .i_mcu_wdata(mcu_wdata),
        .o_mcu_rdata(mcu_rdata), .o_mcu_rdy(mcu_rdy),
        .o_rom_addr(rom_addr), .o_rom_dq(rom_dq_o), .o_rom_dq_oe(rom_dq_oe), .i_rom_dq(rom_dq_i),
        .o_rom_ce_n(rom_ce_n), .o_rom_oe_n(rom_oe_n), .o_rom_we_n(rom_we_n),
        .o_rom_ble_n(rom_ble_n), .o_rom_bhe_n(rom_bhe_n), .o_snes_overrun(snes_overrun)
    );

    // SRAM model indexed by the low word-address byte; drives a marker when not output-enabled
    assign rom_dq_i = (!rom_ce_n && !rom_oe_n) ? mem[rom_addr[7:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_a] <= pre_d;
        else if (!rom_ce_n && !rom_we_n) begin
            if (!rom_ble_n) mem[rom_addr[7:0]][7:0] <= rom_dq_o[7:0];
            if (!rom_bhe_n) mem[rom_addr[7:0]][15:8] <= rom_dq_o[15:8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pre_a = a; pre_d = d; pre_we = 1;
        @(negedge clk);
        pre_we = 0;
    endtask

    typedef struct {
        logic        rd, wr, wrt;
        logic [23:0] addr;
        logic [7:0]  din;
        logic [7:0]  ce, oe, we, dqoe, ble, bhe;
        logic [22:0] radr;
        logic [7:0]  dout;
        logic [7:0]  idx;
        logic [15:0] word;
    } vec_t;

    vec_t v [7];

    initial begin
        logic [7:0]  m_ce, m_oe, m_we, m_dqoe, m_ble, m_bhe;
        logic [15:0] r_mask, c_mask, o_mask, w_mask;
        logic [22:0] s_addr;
        logic [15:0] s_dq;
        logic [7:0]  s_dout, s_rdata, prev_dout;
        int first, n_rdy, cnt91, cnt8, ce_cnt;

        v[0] = '{1,0,0, 24'h000123, 8'h00, 8'h0E,8'h0E,8'h00,8'h00,8'h00,8'h0E, 23'h000091, 8'hA5, 8'h91, 16'hA55A};
        v[1] = '{0,1,1, 24'h600010, 8'h3C, 8'h0E,8'h00,8'h0C,8'h0E,8'h0E,8'h00, 23'h300008, 8'hA5, 8'h08, 16'h113C};
        v[2] = '{0,1,0, 24'h600010, 8'h77, 8'h00,8'h00,8'h00,8'h00,8'h00,8'h00, 23'h300008, 8'hA5, 8'h08, 16'h113C};
        v[3] = '{1,0,0, 24'h600011, 8'h00, 8'h0E,8'h0E,8'h00,8'h00,8'h00,8'h0E, 23'h300008, 8'h11, 8'h08, 16'h113C};
        v[4] = '{1,0,0, 24'h600010, 8'h00, 8'h0E,8'h0E,8'h00,8'h00,8'h0E,8'h00, 23'h300008, 8'h3C, 8'h08, 16'h113C};
        v[5] = '{0,1,1, 24'h000123, 8'hE7, 8'h0E,8'h00,8'h0C,8'h0E,8'h00,8'h0E, 23'h000091, 8'h3C, 8'h91, 16'hE75A};
        v[6] = '{1,0,0, 24'h000122, 8'h00, 8'h0E,8'h0E,8'h00,8'h00,8'h0E,8'h00, 23'h000091, 8'h5A, 8'h91, 16'hE75A};

        @(negedge clk);
        preload(8'h91, 16'hA55A);
        preload(8'h08, 16'h1111);
        preload(8'h00, 16'hBEEF);
        chk("rst_ce_n", rom_ce_n, 1);
        chk("rst_strobes", {rom_oe_n, rom_we_n, rom_ble_n, rom_bhe_n, rom_dq_oe}, 5'b11110);
        chk("rst_outs", {snes_dout, mcu_rdata, mcu_rdy, snes_overrun}, 18'h0);
        chk("rst_addr", rom_addr, 0);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            snes_rd_start = v[i].rd; snes_wr_end = v[i].wr; map_writable = v[i].wrt;
            map_addr = v[i].addr; snes_din = v[i].din;
            @(negedge clk);
            snes_rd_start = 0; snes_wr_end = 0; map_writable = 0;
            {m_ce, m_oe, m_we, m_dqoe, m_ble, m_bhe} = '0;
            s_addr = '0; s_dq = '0; s_dout = '0;
            for (int k = 1; k <= 6; k++) begin
                m_ce[k] = ~rom_ce_n; m_oe[k] = ~rom_oe_n; m_we[k] = ~rom_we_n;
                m_dqoe[k] = rom_dq_oe; m_ble[k] = ~rom_ble_n; m_bhe[k] = ~rom_bhe_n;
                if (k == 2) begin s_addr = rom_addr; s_dq = rom_dq_o; end
                if (k == 4) s_dout = snes_dout;
                @(negedge clk);
            end
            chk($sformatf("v%0d_ce", i), m_ce, v[i].ce);
            chk($sformatf("v%0d_oe", i), m_oe, v[i].oe);
            chk($sformatf("v%0d_we", i), m_we, v[i].we);
            chk($sformatf("v%0d_dqoe", i), m_dqoe, v[i].dqoe);
            chk($sformatf("v%0d_ble", i), m_ble, v[i].ble);
            chk($sformatf("v%0d_bhe", i), m_bhe, v[i].bhe);
            chk($sformatf("v%0d_addr", i), s_addr, v[i].radr);
            chk($sformatf("v%0d_dout", i), s_dout, v[i].dout);
            chk($sformatf("v%0d_mem", i), mem[v[i].idx], v[i].word);
            if (v[i].wr && v[i].wrt) chk($sformatf("v%0d_dq", i), s_dq, {v[i].din, v[i].din});
        end

        // MCU read in flight, SNES read arrives one cycle later and waits behind it
        mcu_addr = 24'hC00000; mcu_rrq = 1;
        @(negedge clk);
        r_mask = '0; first = 0; s_rdata = '0; prev_dout = '0;
        for (int k = 1; k <= 11; k++) begin
            snes_rd_start = (k == 1); map_addr = 24'h000123;
            if (mcu_rdy) begin r_mask[k] = 1; s_rdata = mcu_rdata; mcu_rrq = 0; end
            if (k == 8) prev_dout = snes_dout;
            if (first == 0 && snes_dout == 8'hE7) first = k;
            @(negedge clk);
        end
        chk("mcu_first_rdy", r_mask, 16'h0010);
        chk("mcu_first_rdata", s_rdata, 8'hEF);
        chk("snes_behind_mcu_cycle", first, 9);
        chk("snes_dout_before", prev_dout, 8'h5A);

        // both MCU requests: read first, then write
        mcu_addr = 24'hC00001; mcu_wdata = 8'h99; mcu_rrq = 1; mcu_wrq = 1;
        @(negedge clk);
        r_mask = '0; c_mask = '0; o_mask = '0; w_mask = '0; n_rdy = 0; s_rdata = '0;
        for (int k = 1; k <= 11; k++) begin
            c_mask[k] = ~rom_ce_n; o_mask[k] = ~rom_oe_n; w_mask[k] = ~rom_we_n;
            if (mcu_rdy) begin
                r_mask[k] = 1; n_rdy++;
                if (n_rdy == 1) begin s_rdata = mcu_rdata; mcu_rrq = 0; end
                else mcu_wrq = 0;
            end
            @(negedge clk);
        end
        chk("mcu_rw_rdy", r_mask, 16'h0210);
        chk("mcu_rw_ce", c_mask, 16'h01CE);
        chk("mcu_rw_oe", o_mask, 16'h000E);
        chk("mcu_rw_we", w_mask, 16'h0180);
        chk("mcu_rw_rdata", s_rdata, 8'hBE);
        chk("mcu_rw_mem", mem[0], 16'h99EF);

        // two SNES reads while the MCU is busy: only the second one runs
        chk("overrun_before", snes_overrun, 0);
        mcu_addr = 24'hC00000; mcu_rrq = 1;
        @(negedge clk);
        cnt91 = 0; cnt8 = 0;
        for (int k = 1; k <= 11; k++) begin
            snes_rd_start = (k == 1 || k == 2);
            map_addr = (k == 1) ? 24'h000122 : 24'h600011;
            if (!rom_ce_n && rom_addr == 23'h000091) cnt91++;
            if (!rom_ce_n && rom_addr == 23'h300008) cnt8++;
            if (mcu_rdy) mcu_rrq = 0;
            @(negedge clk);
        end
        chk("overrun_first_skipped", cnt91, 0);
        chk("overrun_second_cycles", cnt8, 3);
        chk("overrun_dout", snes_dout, 8'h11);
        chk("overrun_flag", snes_overrun, 1);

        // asynchronous reset in cycle 2 of a write, with a read pending
        snes_wr_end = 1; map_writable = 1; map_addr = 24'h600010; snes_din = 8'h55;
        @(negedge clk);
        snes_wr_end = 0; map_writable = 0;
        snes_rd_start = 1; map_addr = 24'h000123;
        @(negedge clk);
        snes_rd_start = 0;
        chk("rst_mid_we_low", rom_we_n, 0);
        rst_n = 0;
        #1;
        chk("rst_mid_we_n", rom_we_n, 1);
        chk("rst_mid_ce_n", rom_ce_n, 1);
        chk("rst_mid_dq_oe", rom_dq_oe, 0);
        chk("rst_mid_outs", {snes_overrun, snes_dout, rom_addr}, 32'h0);
        @(negedge clk);
        rst_n = 1;
        ce_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (!rom_ce_n) ce_cnt++;
            @(negedge clk);
        end
        chk("rst_no_pending", ce_cnt, 0);
        chk("rst_write_abandoned", mem[8'h08], 16'h113C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
